// File: rtl/pwm_demodulator_if.sv
// Link-side signal bundle for the PWM receiver: pin inputs in, recovered word out.
interface pwm_demodulator_if #(
  parameter int Size = 4
);
  logic            PWM;
  logic            Sign;
  logic [Size-1:0] Data;
  logic            Valid;
  logic            PeriodError;

  modport master (output PWM, Sign, input Data, Valid, PeriodError);
  modport slave  (input PWM, Sign, output Data, Valid, PeriodError);
endinterface

// File: rtl/pwm_demodulator.sv
// Recovers a Size-bit word from a front-aligned PWM stream plus sign line.
// High time is measured in prescaled ticks; a watchdog restarted by every edge covers stuck lines.
module pwm_demodulator #(
  parameter int ClockPeriod_ns = 20,
  parameter int PWMPeriod_ns   = 200_000,
  parameter int Size           = 4,
  parameter     TypeData       = "Sign",
  parameter int SyncStages     = 2
) (
  input logic              Clock,
  input logic              nReset,
  pwm_demodulator_if.slave link
);
  localparam bit IsSign       = (TypeData == "Sign");
  localparam int Max          = IsSign ? 2**(Size-1) - 2 : 2**Size - 2;
  localparam int PRaw         = PWMPeriod_ns / ClockPeriod_ns / (Max + 1);
  localparam int P            = (PRaw < 1) ? 1 : PRaw;
  localparam int NMag         = IsSign ? Size - 1 : Size;
  localparam int FullScale    = 2**NMag - 1;
  localparam int TimeoutTicks = Max + 2;
  localparam int TimeoutClk   = TimeoutTicks * P;
  localparam int SW           = (P > 1) ? $clog2(P) : 1;
  localparam int TW           = $clog2(2 * TimeoutTicks + 2);
  localparam int OW           = $clog2(TimeoutClk + 1);
  localparam int MW           = TW + 1;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t                state_q;
  logic [SyncStages-1:0] pwm_sync_q, sign_sync_q;
  logic                  spwm_prev_q, signl_q, valid_q, perr_q;
  logic [Size-1:0]       data_q;
  logic [NMag-1:0]       duty_q;
  logic [SW-1:0]         sub_q, sub_d;
  logic [TW-1:0]         tick_q, tick_d;
  logic [OW-1:0]         to_q, to_d;
  logic                  spwm, ssign, rise, fall, to_hit, tmo;
  logic [MW-1:0]         ticks;
  logic [NMag-1:0]       mag;

  assign spwm   = pwm_sync_q[SyncStages-1];
  assign ssign  = sign_sync_q[SyncStages-1];
  assign rise   = spwm & ~spwm_prev_q;
  assign fall   = ~spwm & spwm_prev_q;
  assign to_hit = (to_q == OW'(TimeoutClk - 1));
  // An edge in the same cycle as the watchdog expiry takes priority.
  assign tmo    = to_hit & ~(rise | fall);
  assign to_d   = (rise | fall | to_hit) ? '0 : to_q + 1'b1;

  assign ticks = MW'(tick_q) + MW'(sub_q >= SW'(P / 2));
  assign mag   = (ticks > MW'(FullScale)) ? NMag'(FullScale) : ticks[NMag-1:0];

  // The edge-detect cycle itself counts as one elapsed clock, so the
  // counters load "one clock" rather than zero on a rise.
  always_comb begin
    sub_d  = sub_q + 1'b1;
    tick_d = tick_q;
    if (rise) begin
      sub_d  = (P > 1) ? SW'(1) : '0;
      tick_d = (P > 1) ? '0 : TW'(1);
    end else if (sub_q == SW'(P - 1)) begin
      sub_d = '0;
      if (tick_q != '1) tick_d = tick_q + 1'b1;
    end
  end

  function automatic logic [Size-1:0] pack(input logic s, input logic [NMag-1:0] m);
    logic [Size-1:0] r;
    r = Size'(m);
    if (IsSign) r[Size-1] = s;
    return r;
  endfunction

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q     <= IDLE;
      pwm_sync_q  <= '0;
      sign_sync_q <= '0;
      spwm_prev_q <= 1'b0;
      sub_q       <= '0;
      tick_q      <= '0;
      to_q        <= '0;
      signl_q     <= 1'b0;
      duty_q      <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      pwm_sync_q  <= {pwm_sync_q[SyncStages-2:0], link.PWM};
      sign_sync_q <= {sign_sync_q[SyncStages-2:0], link.Sign};
      spwm_prev_q <= spwm;
      sub_q       <= sub_d;
      tick_q      <= tick_d;
      to_q        <= to_d;
      valid_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_q <= HIGH;
          end else if (tmo) begin
            data_q  <= pack(ssign, spwm ? NMag'(FullScale) : '0);
            perr_q  <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        HIGH: begin
          if (fall) begin
            duty_q  <= mag;
            signl_q <= ssign;
            state_q <= LOW;
          end else if (tmo) begin
            signl_q <= ssign;
            data_q  <= pack(ssign, NMag'(FullScale));
            perr_q  <= 1'b0;
            valid_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        LOW: begin
          if (rise) begin
            data_q  <= pack(signl_q, duty_q);
            perr_q  <= (ticks != MW'(Max + 1));
            valid_q <= 1'b1;
            state_q <= HIGH;
          end else if (tmo) begin
            data_q  <= pack(signl_q, duty_q);
            perr_q  <= 1'b0;
            valid_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign link.Data        = data_q;
  assign link.Valid       = valid_q;
  assign link.PeriodError = perr_q;
endmodule

// File: tb/tb_pwm_demodulator.sv
// Bench for pwm_demodulator: table of PWM periods plus stuck-line and reset sequences,
// expected words queued at the period-ending edge and matched against each Valid.
module tb_pwm_demodulator;
  localparam int NV = 15;

  logic Clock = 1'b0;
  logic nReset;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    int         hi;
    int         lo;
    logic       s;
    logic [3:0] d;
    logic       pe;
  } vec_t;

  typedef struct {
    logic [3:0] d;
    logic       pe;
    int         id;
  } exp_t;

  vec_t vecs[NV];
  exp_t exp_q[$];

  pwm_demodulator_if #(.Size(4)) bus ();

  pwm_demodulator #(
    .ClockPeriod_ns(20),
    .PWMPeriod_ns  (560),
    .Size          (4),
    .TypeData      ("Sign"),
    .SyncStages    (2)
  ) dut (
    .Clock (Clock),
    .nReset(nReset),
    .link  (bus)
  );

  always #10 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] d, input logic pe, input int id);
    exp_t e;
    e.d  = d;
    e.pe = pe;
    e.id = id;
    exp_q.push_back(e);
  endtask

  task automatic drive_period(input int hi, input int lo, input logic s);
    bus.PWM  = 1'b1;
    bus.Sign = s;
    repeat (hi) @(negedge Clock);
    bus.PWM = 1'b0;
    repeat (lo) @(negedge Clock);
  endtask

  // Every Valid must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clock);
      if (nReset && bus.Valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid actual=valid data=%b required=no valid", bus.Data);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("data#%0d", e.id), 32'(bus.Data), 32'(e.d));
          check($sformatf("perr#%0d", e.id), 32'(bus.PeriodError), 32'(e.pe));
        end
      end
    end
  end

  initial begin
    //          hi  lo  sign  data     perr
    vecs[0]  = '{12, 16, 1'b1, 4'b1011, 1'b0};
    vecs[1]  = '{12, 16, 1'b1, 4'b1011, 1'b0};
    vecs[2]  = '{13, 15, 1'b0, 4'b0011, 1'b0};
    vecs[3]  = '{14, 14, 1'b0, 4'b0100, 1'b0};
    vecs[4]  = '{ 8, 28, 1'b0, 4'b0010, 1'b1};
    vecs[5]  = '{ 4, 24, 1'b1, 4'b1001, 1'b0};
    vecs[6]  = '{ 2, 26, 1'b0, 4'b0001, 1'b0};
    vecs[7]  = '{26,  2, 1'b1, 4'b1111, 1'b0};
    vecs[8]  = '{30, 10, 1'b0, 4'b0111, 1'b1};
    vecs[9]  = '{12, 12, 1'b1, 4'b1011, 1'b1};
    vecs[10] = '{ 5, 23, 1'b0, 4'b0001, 1'b0};
    vecs[11] = '{12, 15, 1'b1, 4'b1011, 1'b0};
    vecs[12] = '{12, 17, 1'b0, 4'b0011, 1'b0};
    vecs[13] = '{12, 14, 1'b1, 4'b1011, 1'b0};
    vecs[14] = '{12, 13, 1'b0, 4'b0011, 1'b1};

    nReset   = 1'b0;
    bus.PWM  = 1'b0;
    bus.Sign = 1'b0;
    repeat (3) @(negedge Clock);
    check("reset_data",  32'(bus.Data),        32'h0);
    check("reset_valid", 32'(bus.Valid),       32'h0);
    check("reset_perr",  32'(bus.PeriodError), 32'h0);
    nReset = 1'b1;
    repeat (2) @(negedge Clock);

    // Each period's word is published by the rise that starts the next one.
    for (int i = 0; i < NV; i++) begin
      if (i > 0) push(vecs[i-1].d, vecs[i-1].pe, i - 1);
      drive_period(vecs[i].hi, vecs[i].lo, vecs[i].s);
    end
    push(vecs[NV-1].d, vecs[NV-1].pe, NV - 1);

    // Line stuck high: HIGH watchdog then one IDLE watchdog, both full scale.
    bus.PWM  = 1'b1;
    bus.Sign = 1'b0;
    push(4'b0111, 1'b0, 100);
    push(4'b0111, 1'b0, 101);
    repeat (70) @(negedge Clock);

    // Line stuck low: zero every 8 ticks, sign follows the live line.
    bus.PWM = 1'b0;
    push(4'b0000, 1'b0, 102);
    push(4'b0000, 1'b0, 103);
    push(4'b1000, 1'b0, 104);
    repeat (70) @(negedge Clock);
    bus.Sign = 1'b1;
    repeat (30) @(negedge Clock);

    // Reset mid-HIGH clears outputs at once; next word needs rise-fall-rise.
    bus.PWM = 1'b1;
    repeat (6) @(negedge Clock);
    #3 nReset = 1'b0;
    #1;
    check("async_rst_data",  32'(bus.Data),        32'h0);
    check("async_rst_valid", 32'(bus.Valid),       32'h0);
    check("async_rst_perr",  32'(bus.PeriodError), 32'h0);
    repeat (3) @(negedge Clock);
    nReset = 1'b1;
    repeat (12) @(negedge Clock);
    bus.PWM = 1'b0;
    repeat (16) @(negedge Clock);
    push(4'b1011, 1'b0, 105);
    bus.PWM = 1'b1;

    for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge Clock);
    check("drain_left", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
